// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches and buffers the responses
// for the decoder. Branch/jump redirects flush the buffer and drop any in-flight responses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | normal operation, requests issued while buffer credit remains
// S_FLUSH | after redirect, discarding responses to pre-redirect requests
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  opcode,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [0:0]    state_q, state_d;
   logic          run_q;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] outs_q, outs_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] pq_wr_q, pq_rd_q, f_wr_q, f_rd_q;
   logic [31:0]   pq_mem [FIFO_DEPTH];
   logic [31:0]   fd_mem [FIFO_DEPTH];
   logic [31:0]   fp_mem [FIFO_DEPTH];
   logic          pop, rsp_fire, acc, push;
   logic [CW:0]   credit;

   assign instr_valid = (cnt_q != '0);
   assign pop         = instr_valid && instr_ready;
   // Responses with nothing outstanding are protocol violations and are ignored.
   assign rsp_fire    = imem_rsp_valid && (outs_q != '0);
   assign credit      = {1'b0, outs_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};

   assign imem_req_valid = run_q && (state_q == S_FETCH) && !redirect_valid && (credit < DEPTH_C);
   assign imem_addr      = pc_q;
   assign acc            = imem_req_valid && imem_req_ready;
   assign push           = rsp_fire && (state_q == S_FETCH) && !redirect_valid;

   assign instr    = fd_mem[f_rd_q];
   assign instr_pc = fp_mem[f_rd_q];
   assign opcode   = instr[6:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      outs_d  = outs_q;
      cnt_d   = cnt_q;
      if (acc && !rsp_fire)      outs_d = outs_q + 1'b1;
      else if (!acc && rsp_fire) outs_d = outs_q - 1'b1;
      if (redirect_valid)        cnt_d = '0;
      else if (push && !pop)     cnt_d = cnt_q + 1'b1;
      else if (!push && pop)     cnt_d = cnt_q - 1'b1;
      if (redirect_valid) begin
         // No request is offered on a redirect cycle, so outs_d is exactly what must be dropped.
         pc_d    = redirect_pc & 32'hFFFF_FFFC;
         drop_d  = outs_d;
         state_d = (outs_d != '0) ? S_FLUSH : S_FETCH;
      end else if (state_q == S_FLUSH) begin
         if (rsp_fire) drop_d = drop_q - 1'b1;
         if (drop_d == '0) state_d = S_FETCH;
      end else if (acc) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
         pc_q    <= RESET_PC;
         outs_q  <= '0;
         drop_q  <= '0;
         cnt_q   <= '0;
         pq_wr_q <= '0;
         pq_rd_q <= '0;
         f_wr_q  <= '0;
         f_rd_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pq_mem[i] <= '0;
            fd_mem[i] <= '0;
            fp_mem[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         pc_q    <= pc_d;
         outs_q  <= outs_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         if (redirect_valid) begin
            pq_wr_q <= '0;
            pq_rd_q <= '0;
            f_wr_q  <= '0;
            f_rd_q  <= '0;
         end else begin
            if (acc) begin
               pq_mem[pq_wr_q] <= pc_q;
               pq_wr_q         <= pq_wr_q + 1'b1;
            end
            if (push) begin
               fd_mem[f_wr_q] <= imem_rsp_data;
               fp_mem[f_wr_q] <= pq_mem[pq_rd_q];
               f_wr_q         <= f_wr_q + 1'b1;
               pq_rd_q        <= pq_rd_q + 1'b1;
            end
            if (pop) f_rd_q <= f_rd_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-randomised in-order memory model plus an expected
// PC-stream model (sequential +4, restart at redirect target) checked every cycle.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        instr_valid;
   logic        instr_ready    = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .opcode(opcode),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rdy_prob = 100, irdy_prob = 100, rsp_prob = 100, lat_min = 1, lat_max = 1;
   bit force_rsp = 1'b0;
   bit mon_en = 1'b0;

   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] exp_pc, exp_req_pc, last_acc_addr, last_del_pc;
   int          acc_cnt = 0, del_cnt = 0;
   logic [31:0] acc_log[$], del_log[$];
   logic [6:0]  op_log[$];
   bit          prev_stall, prev_redir, prev_hold;
   logic [31:0] prev_addr, prev_instr, prev_ipc;

   // Instruction image: low 7 bits give ADDI at addr[2]=0 and ADD at addr[2]=1.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:7] ^ 25'h0AB_CDE1, a[2] ? 7'h33 : 7'h13};
   endfunction

   // Memory and decoder handshake driver.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      imem_req_ready = (int'($urandom_range(99)) < rdy_prob);
      instr_ready    = (int'($urandom_range(99)) < irdy_prob);
      if (force_rsp) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = $urandom;
      end else if (mq_addr.size() != 0 && mq_due[0] <= cyc && int'($urandom_range(99)) < rsp_prob) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   end

   // One clock: sample at negedge, update memory and stream models, check, return at posedge+2.
   task automatic tick();
      logic acc, pop;
      logic [31:0] w;
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      pop = instr_valid && instr_ready;
      if (!rst_n) begin
         mq_addr.delete();
         mq_due.delete();
         exp_pc     = RST_PC;
         exp_req_pc = RST_PC;
      end else begin
         if (imem_rsp_valid && mq_addr.size() != 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
         if (acc) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
         end
      end
      if (mon_en && rst_n) begin
         if (imem_req_valid) begin
            n_checks++;
            if (imem_addr[1:0] !== 2'b00) begin
               n_errors++; $display("FAIL addr_align: got %h, low bits must be 00", imem_addr);
            end
         end
         if (prev_stall && !redirect_valid) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr) begin
               n_errors++; $display("FAIL stall_hold: got valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_addr, prev_addr);
            end
         end
         if (redirect_valid) begin
            n_checks++;
            if (imem_req_valid !== 1'b0) begin
               n_errors++; $display("FAIL req_on_redirect: got %b expected 0", imem_req_valid);
            end
         end
         if (acc) begin
            n_checks++;
            if (imem_addr !== exp_req_pc) begin
               n_errors++; $display("FAIL req_addr: got %h expected %h", imem_addr, exp_req_pc);
            end
            last_acc_addr = imem_addr;
            acc_log.push_back(imem_addr);
            acc_cnt++;
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (prev_redir) begin
            n_checks++;
            if (instr_valid !== 1'b0) begin
               n_errors++; $display("FAIL valid_after_redirect: got %b expected 0", instr_valid);
            end
         end else if (prev_hold) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_ipc) begin
               n_errors++; $display("FAIL instr_hold: got v=%b %h@%h expected v=1 %h@%h", instr_valid, instr, instr_pc, prev_instr, prev_ipc);
            end
         end
         if (pop) begin
            w = mem_word(exp_pc);
            n_checks++;
            if (instr_pc !== exp_pc || instr !== w || opcode !== w[6:0]) begin
               n_errors++; $display("FAIL deliver: got pc=%h instr=%h op=%h expected pc=%h instr=%h op=%h", instr_pc, instr, opcode, exp_pc, w, w[6:0]);
            end
            last_del_pc = instr_pc;
            del_log.push_back(instr_pc);
            op_log.push_back(opcode);
            del_cnt++;
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) begin
            exp_pc     = redirect_pc & 32'hFFFF_FFFC;
            exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
         end
         prev_stall = imem_req_valid && !imem_req_ready;
         prev_addr  = imem_addr;
         prev_redir = redirect_valid;
         prev_hold  = instr_valid && !instr_ready;
         prev_instr = instr;
         prev_ipc   = instr_pc;
      end else begin
         prev_stall = 1'b0;
         prev_redir = 1'b0;
         prev_hold  = 1'b0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mon_en = 1'b0;
      redirect_valid = 1'b0;
      repeat (3) tick();
      acc_log.delete(); del_log.delete(); op_log.delete();
      rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic wait_delivery(input string name, input logic [31:0] want);
      int d0 = del_cnt;
      for (int i = 0; i < 60 && del_cnt == d0; i++) tick();
      n_checks++;
      if (del_cnt == d0) begin
         n_errors++; $display("FAIL %s: no delivery within 60 cycles, expected pc %h", name, want);
      end else if (last_del_pc !== want) begin
         n_errors++; $display("FAIL %s: got pc %h expected %h", name, last_del_pc, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mon_en = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (imem_req_valid !== 1'b0 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_req: got v=%b addr=%h iv=%b expected 0 %h 0", imem_req_valid, imem_addr, instr_valid, RST_PC);
      end
      n_checks++;
      if (instr !== 32'h0 || instr_pc !== 32'h0 || opcode !== 7'h0) begin
         n_errors++; $display("FAIL reset_instr: got %h %h %h expected zeros", instr, instr_pc, opcode);
      end
      rst_n = 1'b1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_early_req: got %b expected 0", imem_req_valid);
      end
      mon_en = 1'b1;
      tick();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
         n_errors++; $display("FAIL first_req: got v=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, RST_PC);
      end
   endtask

   task automatic test_sequential();
      int d0;
      logic [31:0] exp_seq [4];
      rdy_prob = 100; irdy_prob = 100; rsp_prob = 100; lat_min = 1; lat_max = 1;
      do_reset();
      exp_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      repeat (20) tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (acc_log.size() <= i || acc_log[i] !== exp_seq[i]) begin
            n_errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, (acc_log.size() > i) ? acc_log[i] : 32'hX, exp_seq[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (del_log.size() <= i || del_log[i] !== exp_seq[i]) begin
            n_errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, (del_log.size() > i) ? del_log[i] : 32'hX, exp_seq[i]);
         end
      end
      n_checks++;
      if (op_log.size() < 4 || op_log[2] !== 7'h13 || op_log[3] !== 7'h33) begin
         n_errors++; $display("FAIL seq_opcode: got %h %h expected 13 33", (op_log.size() > 2) ? op_log[2] : 7'hX, (op_log.size() > 3) ? op_log[3] : 7'hX);
      end
      d0 = del_cnt;
      repeat (10) tick();
      n_checks++;
      if (del_cnt - d0 != 10) begin
         n_errors++; $display("FAIL throughput: got %0d deliveries in 10 cycles expected 10", del_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int a0, d0;
      logic [31:0] hpc;
      irdy_prob = 0;
      tick();
      a0 = acc_cnt;
      hpc = instr_pc;
      repeat (10) tick();
      n_checks++;
      if (acc_cnt - a0 > DEPTH) begin
         n_errors++; $display("FAIL bp_credit: got %0d accepts while stalled expected <= %0d", acc_cnt - a0, DEPTH);
      end
      n_checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== hpc) begin
         n_errors++; $display("FAIL bp_state: got req=%b iv=%b pc=%h expected 0 1 %h", imem_req_valid, instr_valid, instr_pc, hpc);
      end
      irdy_prob = 100;
      d0 = del_cnt;
      repeat (20) tick();
      n_checks++;
      if (del_cnt - d0 < 10) begin
         n_errors++; $display("FAIL bp_release: got %0d deliveries expected >= 10", del_cnt - d0);
      end
   endtask

   task automatic test_redirect_flush();
      int a0;
      rdy_prob = 100; irdy_prob = 100; rsp_prob = 100; lat_min = 6; lat_max = 6;
      do_reset();
      for (int i = 0; i < 40 && !(mq_addr.size() == 2 && !imem_rsp_valid); i++) tick();
      n_checks++;
      if (!(mq_addr.size() == 2 && !imem_rsp_valid)) begin
         n_errors++; $display("FAIL flush_setup: got %0d outstanding expected 2", mq_addr.size());
      end
      a0 = acc_cnt;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
         n_errors++; $display("FAIL flush_req: got %b expected 0", imem_req_valid);
      end
      for (int i = 0; i < 40 && acc_cnt == a0; i++) tick();
      n_checks++;
      if (acc_cnt == a0 || last_acc_addr !== 32'h0000_0100 || mq_addr.size() != 1) begin
         n_errors++; $display("FAIL flush_next_req: got addr=%h inflight=%0d expected 00000100 1", last_acc_addr, mq_addr.size());
      end
      wait_delivery("flush_first_pc", 32'h0000_0100);
   endtask

   task automatic test_redirect_push_pop();
      logic [31:0] t;
      bit found = 1'b0;
      rdy_prob = 100; irdy_prob = 100; rsp_prob = 100; lat_min = 1; lat_max = 1;
      repeat (8) tick();
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_rsp_valid && instr_valid && instr_ready) found = 1'b1;
         else tick();
      end
      n_checks++;
      if (!found) begin
         n_errors++; $display("FAIL pushpop_setup: got no push+pop cycle expected one");
      end
      t = $urandom;
      redirect_valid = 1'b1;
      redirect_pc = t;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if (instr_valid !== 1'b0) begin
         n_errors++; $display("FAIL pushpop_flush: got valid %b expected 0", instr_valid);
      end
      wait_delivery("pushpop_first_pc", t & 32'hFFFF_FFFC);
   endtask

   task automatic test_spurious_rsp();
      rdy_prob = 0; irdy_prob = 100; lat_min = 1; lat_max = 1;
      do_reset();
      force_rsp = 1'b1;
      repeat (4) begin
         tick();
         n_checks++;
         if (instr_valid !== 1'b0) begin
            n_errors++; $display("FAIL spurious_rsp: got valid %b expected 0", instr_valid);
         end
      end
      force_rsp = 1'b0;
      rdy_prob = 100;
      tick();
      wait_delivery("spurious_recover", RST_PC);
   endtask

   task automatic test_random();
      int d0;
      rdy_prob = 50; irdy_prob = 70; rsp_prob = 60; lat_min = 1; lat_max = 4;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         redirect_valid = ($urandom_range(99) < 4);
         redirect_pc = $urandom;
         tick();
      end
      redirect_valid = 1'b0;
      rdy_prob = 100; irdy_prob = 100; rsp_prob = 100; lat_min = 1; lat_max = 1;
      d0 = del_cnt;
      repeat (60) tick();
      n_checks++;
      if (del_cnt - d0 < 30) begin
         n_errors++; $display("FAIL random_drain: got %0d deliveries expected >= 30", del_cnt - d0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      @(posedge clk);
      #2;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_flush();
      test_redirect_push_pop();
      test_spurious_rsp();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, byte address of first fetch after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, 2, instruction buffer entries; power of 2, >=2.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_addr  output  32  request byte address; [1:0] always 0.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; in request order, >=1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction offered to decoder.
REQ-011 SHALL have port instr_ready  input  1  decoder accepts.
REQ-012 SHALL have port instr  output  32  instruction word.
REQ-013 SHALL have port instr_pc  output  32  PC of instr.
REQ-014 SHALL have port opcode  output  7  instr[6:0], drives control-unit opcode input.
REQ-015 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-016 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored.

Function
REQ-017 SHALL implement states FETCH and FLUSH; reset enters FETCH.
REQ-018 SHALL accept a request on a cycle with imem_req_valid && imem_req_ready, advancing pc by 4 at that edge, wrapping 32'hFFFF_FFFC -> 0.
REQ-019 SHALL hold imem_addr and imem_req_valid stable while imem_req_valid && !imem_req_ready, except on redirect.
REQ-020 SHALL assert imem_req_valid only in FETCH, without redirect_valid, and when outstanding + fifo_count - pop < FIFO_DEPTH (pop = instr_valid && instr_ready); credit rule guarantees no FIFO overflow.
REQ-021 SHALL count outstanding requests: +1 on accept, -1 on response, unchanged on both same cycle; width holds 0..FIFO_DEPTH.
REQ-022 SHALL queue the PC of each accepted request and attach it to the matching response as instr_pc.
REQ-023 SHALL push each non-discarded response into the FIFO; instr_valid rises the cycle after the response (1-cycle latency when FIFO empty).
REQ-024 SHALL allow push and pop on the same cycle, count unchanged.
REQ-025 SHALL hold instr, instr_pc, opcode stable while instr_valid && !instr_ready.
REQ-026 SHALL give redirect_valid priority over all other events: at that edge flush FIFO and PC queue, instr_valid = 0 next cycle, pc <= {redirect_pc[31:2],2'b00}, no request offered that cycle.
REQ-027 SHALL on redirect set drop_count = outstanding - (response this cycle); nonzero -> FLUSH, zero -> FETCH.
REQ-028 SHALL in FLUSH keep imem_req_valid = 0, discard each response decrementing drop_count, return to FETCH the cycle after drop_count reaches 0.
REQ-029 SHALL on redirect during FLUSH update pc and recompute drop_count per REQ-027.
REQ-030 SHALL ignore imem_rsp_valid when outstanding = 0 (protocol violation, no state change).

Reset
REQ-031 SHALL while rst_n = 0 at a clk edge set: state FETCH, pc RESET_PC, imem_req_valid 0, imem_addr RESET_PC, outstanding 0, drop_count 0, FIFO empty, instr_valid 0, instr 0, instr_pc 0, opcode 0.
REQ-032 SHALL offer the first request (addr RESET_PC) the first cycle after rst_n samples 1.
REQ-033 SHALL on reset mid-operation abandon all in-flight state; later responses to pre-reset requests are the memory's responsibility to suppress.

Verification
REQ-034 Reset, zero-wait 1-cycle memory, instr_ready=1 -> instr_pc 0,4,8,12... one per cycle after warm-up, opcode = instr[6:0] (0x33 for ADD, 0x13 for ADDI).
REQ-035 instr_ready=0 for 10 cycles -> at most FIFO_DEPTH buffered, imem_req_valid=0 once credit exhausted, instr held; release -> order preserved, no loss.
REQ-036 Redirect to 0x0000_0103 with 2 outstanding -> FLUSH, 2 responses dropped, next request addr 0x0000_0100, first delivered instr_pc 0x0000_0100.
REQ-037 Redirect on same cycle as push and pop -> FIFO empty next cycle, instr_valid 0, no stale instr delivered.
REQ-038 RESET_PC=32'hFFFF_FFF8, sequential fetch -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 imem_req_ready toggled randomly -> imem_addr stable while stalled, no duplicate or skipped PC.
